// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: opcodes, instruction formats, the field
// bundle carried down the encoder pipeline, and the immediate range check.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
  } fields_t;

  function automatic fmt_e classify(input logic [6:0] op);
    case (op)
      OP_R:                       return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   return FMT_I;
      OP_STORE:                   return FMT_S;
      OP_BRANCH:                  return FMT_B;
      OP_LUI, OP_AUIPC:           return FMT_U;
      OP_JAL:                     return FMT_J;
      default:                    return FMT_ILLEGAL;
    endcase
  endfunction

  // High bits above the field must be a plain zero-extension or a sign-extension.
  function automatic logic imm_out_of_range(input fmt_e fmt, input logic [31:0] imm);
    case (fmt)
      FMT_I, FMT_S: return !(imm[31:12] == '0 || imm[31:12] == {20{imm[11]}});
      FMT_B:        return imm[0] || !(imm[31:13] == '0 || imm[31:13] == {19{imm[12]}});
      FMT_J:        return imm[0] || !(imm[31:21] == '0 || imm[31:21] == {11{imm[20]}});
      FMT_U:        return imm[11:0] != '0;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: classified field bundle -> 32-bit RV32I instruction word.
module instr_pack
  import riscv_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word
);

  always_comb begin
    // NOTE: a default assignment first guarantees no latch for any format value.
    word = NOP;
    case (f.fmt)
      FMT_R: word = {f.func7, f.rs2, f.rs1, f.func3, f.rd, f.opcode};
      FMT_I: word = {f.imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
      FMT_S: word = {f.imm[11:5], f.rs2, f.rs1, f.func3, f.imm[4:0], f.opcode};
      FMT_B: word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.func3,
                     f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: word = NOP;
    endcase
  end

endmodule

// File: rtl/instruction_encode.sv
// Two-stage streaming RV32I encoder with valid/ready on both sides and a byte
// address counter. Define ENCODE_RANGE_CHECK_EN to build the immediate range check.
module instruction_encode
  import riscv_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              out_illegal,
  output logic              out_imm_err
);

  logic        s1_valid, s2_valid;
  fields_t     s1_fields;
  logic [31:0] packed_word;
  logic        s2_advance, out_fire;

  assign out_fire   = s2_valid && out_ready;
  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_valid  = s2_valid;

  // NOTE: datapath fields carry no reset; only valid bits and visible outputs need one.
  always_ff @(posedge clock) begin
    if (in_valid && in_ready)
      s1_fields <= '{fmt: classify(opcode), opcode: opcode, rs1: rs1, rs2: rs2,
                     rd: rd, func3: func3, func7: func7, imm: imm};
  end

  instr_pack u_pack (
    .f    (s1_fields),
    .word (packed_word)
  );

  // NOTE: every sequential assignment is non-blocking so stages update in lockstep.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      instr       <= '0;
      out_illegal <= 1'b0;
      addr        <= RESET_ADDR;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          instr       <= packed_word;
          out_illegal <= (s1_fields.fmt == FMT_ILLEGAL);
        end
      end
      // The load takes priority; the departing word already saw the old address.
      if (addr_load)
        addr <= addr_value;
      else if (out_fire)
        addr <= addr + ADDR_W'(4);
    end
  end

`ifdef ENCODE_RANGE_CHECK_EN
  logic s1_imm_err, s2_imm_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_imm_err <= 1'b0;
      s2_imm_err <= 1'b0;
    end else begin
      if (in_valid && in_ready)
        s1_imm_err <= imm_out_of_range(classify(opcode), imm);
      if (s2_advance && s1_valid)
        s2_imm_err <= s1_imm_err;
    end
  end

  assign out_imm_err = s2_imm_err;
`else
  assign out_imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encode.sv
// Directed self-checking bench for instruction_encode: encoding table, latency,
// backpressure, address load/wrap and mid-operation reset.
module tb_instruction_encode;

`ifdef ENCODE_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid, out_ready;
  logic [31:0] instr, addr;
  logic        out_illegal, out_imm_err;

  int tests  = 0;
  int failed = 0;

  instruction_encode #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func3       (func3),
    .func7       (func7),
    .imm         (imm),
    .addr_load   (addr_load),
    .addr_value  (addr_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr       (instr),
    .addr        (addr),
    .out_illegal (out_illegal),
    .out_imm_err (out_imm_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_illegal;
    logic        exp_err_checked;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    in_valid = 1'b1;
    opcode = op; rs1 = s1; rs2 = s2; rd = d; func3 = f3; func7 = f7; imm = im;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    addr_load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"addi",    7'h13, 5'd2, 5'd0, 5'd1, 3'd0, 7'd0, 32'd5,        32'h00510093, 1'b0, 1'b0};
    vecs[1] = '{"add",     7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        32'h002081B3, 1'b0, 1'b0};
    vecs[2] = '{"sw",      7'h23, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd12,       32'h0020A623, 1'b0, 1'b0};
    vecs[3] = '{"beq",     7'h63, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8,        32'h00208463, 1'b0, 1'b0};
    vecs[4] = '{"jal",     7'h6F, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'h800,      32'h001000EF, 1'b0, 1'b0};
    vecs[5] = '{"lui",     7'h37, 5'd0, 5'd0, 5'd5, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b0};
    vecs[6] = '{"illegal", 7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'h0,        32'h00000013, 1'b1, 1'b0};
    vecs[7] = '{"b_imm5",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00000263, 1'b0, 1'b1};
    vecs[8] = '{"i_big",   7'h13, 5'd0, 5'd0, 5'd1, 3'd0, 7'h7F, 32'h1000,    32'h00000093, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = '0;
    opcode = '0; rs1 = '0; rs2 = '0; rd = '0; func3 = '0; func7 = '0; imm = '0;
    do_reset();

    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset instr", instr, 32'h0);
    check("reset addr", addr, 32'h0);
    check("reset illegal", 32'(out_illegal), 32'd0);
    check("reset imm_err", 32'(out_imm_err), 32'd0);

    // One word at a time with out_ready high: also checks the two-cycle latency.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].f3, vecs[i].f7, vecs[i].imm);
      check({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check({vecs[i].name, " valid early"}, 32'(out_valid), 32'd0);
      tick();
      check({vecs[i].name, " valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, " instr"}, instr, vecs[i].exp_instr);
      check({vecs[i].name, " addr"}, addr, 32'(i * 4));
      check({vecs[i].name, " illegal"}, 32'(out_illegal), 32'(vecs[i].exp_illegal));
      check({vecs[i].name, " imm_err"}, 32'(out_imm_err), 32'(vecs[i].exp_err_checked & RANGE_EN));
    end
    tick();
    check("table drained", 32'(out_valid), 32'd0);

    // Backpressure: three back-to-back words while out_ready is low.
    do_reset();
    out_ready = 1'b0;
    drive(7'h13, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd1);
    tick();
    drive(7'h13, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd2);
    check("bp second accept", 32'(in_ready), 32'd1);
    tick();
    drive(7'h13, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd3);
    for (int c = 0; c < 3; c++) begin
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp valid held", 32'(out_valid), 32'd1);
      check("bp instr stable", instr, 32'h00100093);
      check("bp addr stable", addr, 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready comb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp drain 2 instr", instr, 32'h00200093);
    check("bp drain 2 addr", addr, 32'h4);
    tick();
    check("bp drain 3 instr", instr, 32'h00300093);
    check("bp drain 3 addr", addr, 32'h8);
    tick();
    check("bp drained", 32'(out_valid), 32'd0);
    check("bp final addr", addr, 32'hC);

    // Address load coinciding with the transfer of the word at addr 4.
    do_reset();
    drive(7'h13, 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'd10);
    tick();
    drive(7'h13, 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'd11);
    tick();
    drive(7'h13, 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 32'd12);
    check("ld w0 addr", addr, 32'h0);
    tick();
    in_valid = 1'b0;
    check("ld w1 instr", instr, 32'h00B00113);
    check("ld w1 addr", addr, 32'h4);
    addr_load = 1'b1;
    addr_value = 32'h100;
    tick();
    addr_load = 1'b0;
    check("ld w2 instr", instr, 32'h00C00113);
    check("ld w2 addr", addr, 32'h100);
    tick();
    check("ld after w2", addr, 32'h104);

    // Wrap from the top of the address space.
    addr_load = 1'b1;
    addr_value = 32'hFFFF_FFFC;
    tick();
    addr_load = 1'b0;
    drive(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap word addr", addr, 32'hFFFF_FFFC);
    tick();
    check("wrap addr", addr, 32'h0);

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    drive(7'h13, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'd7);
    tick();
    tick();
    in_valid = 1'b0;
    check("pre-reset full", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset valid", 32'(out_valid), 32'd0);
    check("mid reset addr", addr, 32'h0);
    check("mid reset instr", instr, 32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    check("no stale output", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
